ring_route_compute: RTL and testbench
=====================================

RING_ROUTE_COMPUTE -- requirements
Module: ring_route_compute

Interface
REQ-001 Parameter NUM_NODES, default 8: node count on the bidirectional ring, at least 2.
REQ-002 Parameter ROUTER_ID, default 0: this router's ID, in the range 0..NUM_NODES-1.
REQ-003 Parameter ID_W, default 16: width of the destination-ID field, taken from flit bits [ID_W-1:0].
REQ-004 Parameter PACKET_SIZE, default 49: flit width; bit 32 is the timestamp LSB.
REQ-005 Parameter IN_PORT, default 0: input port served; 0 local, 1 east, 2 west.
REQ-006 Parameter ROUTING, default 0: 0 random oblivious (LFSR), 1 shortest path, 2 clockwise only.
REQ-007 Parameter LFSR_SEED, default 16'hACE1: LFSR reset value; must be nonzero.
REQ-008 clk  in  1  single clock; all logic is rising-edge.
REQ-009 rst  in  1  synchronous reset, active-high.
REQ-010 in_flit  in  PACKET_SIZE  incoming flit.
REQ-011 in_valid  in  1  in_flit is valid.
REQ-012 in_head  in  1  flit is a packet head.
REQ-013 in_tail  in  1  flit is a packet tail; head and tail together mean a single-flit packet.
REQ-014 in_ready  out  1  block can accept a flit this cycle.
REQ-015 out_flit  out  PACKET_SIZE  registered flit.
REQ-016 out_valid  out  1  out_flit and out_dir are valid.
REQ-017 out_ready  in  1  downstream accepts the output.
REQ-018 out_dir  out  2  output port: 00 local (eject), 01 east, 10 west; 11 is never driven.
REQ-019 err  out  1  sticky error flag.

Function
REQ-020 Input transfer occurs when in_valid and in_ready are both high; output transfer occurs when out_valid and out_ready are both high.
REQ-021 in_ready SHALL equal (!out_valid || out_ready), giving a single-stage pipeline with latency 1 and full throughput.
REQ-022 On a transfer, out_flit, out_dir and out_valid SHALL load on the next edge; while out_valid && !out_ready, all outputs hold stable.
REQ-023 FSM states: IDLE and IN_PKT.
- IDLE: an accepted head with !tail moves to IN_PKT; an accepted head with tail stays in IDLE.
- IN_PKT: an accepted tail returns to IDLE.
REQ-024 Route is computed only for head flits; body and tail flits use the latched route of the current packet (wormhole).
REQ-025 A destination equal to ROUTER_ID SHALL give 00 on any port.
REQ-026 On a transit port the route SHALL be straight through: IN_PORT 1 gives 10 and IN_PORT 2 gives 01.
REQ-027 On the local port, per ROUTING:
- Mode 0: LFSR bit0 = 1 gives 10, otherwise 01.
- Mode 1: d = (dest - ROUTER_ID) mod NUM_NODES; d <= NUM_NODES/2 (integer division) gives 01, else 10; a tie goes east.
- Mode 2: always 01.
REQ-028 The modulo in REQ-027 SHALL be computed with ID_W+1-bit arithmetic and no wrap error.
REQ-029 The LFSR is 16-bit Fibonacci, taps 16,14,13,11; it advances by one step only on each accepted local head flit, and only in mode 0.
REQ-030 A destination >= NUM_NODES SHALL set err and route the packet 00 so that it is ejected.
REQ-031 A head accepted in IN_PKT (missing tail) SHALL set err, recompute the route, and apply the FSM transition for a head flit.
REQ-032 A non-head flit accepted in IDLE SHALL set err, be forwarded with dir 00, and leave the FSM in IDLE.
REQ-033 err is cleared only by reset.

Reset
REQ-034 While rst is high at a clock edge:
- out_valid=0, out_dir=00, out_flit=0, err=0;
- FSM=IDLE, latched route=00, LFSR=LFSR_SEED.
REQ-035 Reset mid-packet SHALL discard the packet; the first flit accepted after reset is treated per REQ-032 unless it is a head.
REQ-036 in_ready SHALL be 1 in the first cycle after reset is released.

Structure
REQ-037 A shared package ring_pkg SHALL hold:
- the dir_t enum (DIR_LOCAL=2'b00, DIR_EAST=2'b01, DIR_WEST=2'b10);
- the port constants (PORT_LOCAL, PORT_EAST, PORT_WEST);
- the routing-mode constants (RT_RANDOM, RT_SHORTEST, RT_CW);
- the DEST_LSB and TS_BIT field positions.
REQ-038 The LFSR SHALL be a separate sub-module, ring_lfsr16, with inputs clk, rst, en and seed, and a 16-bit state output.

Verification
REQ-039 NUM_NODES=8, ROUTER_ID=2, IN_PORT=0, ROUTING=1, single-flit heads with dest 5, 6, 7, 2 -> out_dir 01, 01, 10, 00, each one cycle after acceptance.
REQ-040 IN_PORT=1, a 4-flit packet with dest 4, out_ready low for 3 cycles on flit 2 -> all flits out_dir 10, in order, with out_flit held stable and in_ready=0 during the stall.
REQ-041 IN_PORT=0, ROUTING=0, seed 16'hACE1, 8 local heads -> out_dir sequence matches a reference LFSR model; body flits do not advance the LFSR.
REQ-042 Head with dest 9 (NUM_NODES=8) -> out_dir 00 and err=1 from the next cycle; err stays 1 until rst.
REQ-043 Head followed by a head without a tail -> err=1 and the second packet is routed by its own destination; rst asserted mid-packet -> out_valid=0 next cycle and FSM in IDLE.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared ring-router definitions: port directions, port ids, routing modes,
// flit field positions and the 16-bit LFSR step.
package ring_pkg;

  typedef enum logic [1:0] {
    DIR_LOCAL = 2'b00,
    DIR_EAST  = 2'b01,
    DIR_WEST  = 2'b10
  } dir_t;

  typedef enum logic {
    ST_IDLE,
    ST_IN_PKT
  } rr_state_t;

  localparam int PORT_LOCAL = 0;
  localparam int PORT_EAST  = 1;
  localparam int PORT_WEST  = 2;

  localparam int RT_RANDOM   = 0;
  localparam int RT_SHORTEST = 1;
  localparam int RT_CW       = 2;

  localparam int DEST_LSB = 0;
  localparam int TS_BIT   = 32;

  // Fibonacci step for x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/ring_lfsr16.sv
// 16-bit Fibonacci LFSR used for oblivious random routing.
// Latency: state advances one step on the edge after en; no backpressure.
// Loads seed while rst is high.
module ring_lfsr16
  import ring_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= seed;
    end else if (en) begin
      state <= lfsr16_next(state);
    end
  end

endmodule

// File: rtl/ring_route_compute.sv
// Ring router route-compute stage: picks an output port per packet (wormhole).
// Latency 1 cycle, full throughput through a single output register.
// Backpressure: in_ready = !out_valid || out_ready; outputs hold while stalled.
module ring_route_compute
  import ring_pkg::*;
#(
  parameter int          NUM_NODES   = 8,
  parameter int          ROUTER_ID   = 0,
  parameter int          ID_W        = 16,
  parameter int          PACKET_SIZE = 49,
  parameter int          IN_PORT     = 0,
  parameter int          ROUTING     = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PACKET_SIZE-1:0] in_flit,
  input  logic                   in_valid,
  input  logic                   in_head,
  input  logic                   in_tail,
  output logic                   in_ready,
  output logic [PACKET_SIZE-1:0] out_flit,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_dir,
  output logic                   err
);

  localparam logic [ID_W:0] NODES_W  = (ID_W+1)'(NUM_NODES);
  localparam logic [ID_W:0] ROUTER_W = (ID_W+1)'(ROUTER_ID);
  localparam logic [ID_W:0] HALF_W   = (ID_W+1)'(NUM_NODES / 2);

  rr_state_t     state_q, state_d;
  dir_t          route_q, head_dir, dir_sel, dir_q;
  logic          in_fire, err_set, route_load, lfsr_en, lfsr_pick, dest_bad;
  logic [15:0]   lfsr_state;
  logic [ID_W:0] dest_x, diff_raw, diff;

  assign in_ready = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_dir  = dir_q;

  assign lfsr_en   = in_fire && in_head && (IN_PORT == PORT_LOCAL) && (ROUTING == RT_RANDOM);
  assign lfsr_pick = |(lfsr_state & 16'h0001);

  ring_lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (lfsr_en),
    .seed  (LFSR_SEED),
    .state (lfsr_state)
  );

  // One extra bit keeps dest + N - ROUTER_ID from wrapping before the mod.
  assign dest_x   = {1'b0, in_flit[DEST_LSB +: ID_W]};
  assign dest_bad = dest_x >= NODES_W;
  assign diff_raw = dest_x + NODES_W - ROUTER_W;
  assign diff     = (diff_raw >= NODES_W) ? diff_raw - NODES_W : diff_raw;

  always_comb begin
    head_dir = DIR_LOCAL;
    if (dest_bad || dest_x == ROUTER_W) begin
      head_dir = DIR_LOCAL;
    end else if (IN_PORT == PORT_EAST) begin
      head_dir = DIR_WEST;
    end else if (IN_PORT == PORT_WEST) begin
      head_dir = DIR_EAST;
    end else begin
      case (ROUTING)
        RT_RANDOM:   head_dir = lfsr_pick ? DIR_WEST : DIR_EAST;
        RT_SHORTEST: head_dir = (diff <= HALF_W) ? DIR_EAST : DIR_WEST;
        default:     head_dir = DIR_EAST;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dir_sel    = route_q;
    err_set    = 1'b0;
    route_load = 1'b0;
    if (in_fire) begin
      if (in_head) begin
        dir_sel    = head_dir;
        route_load = 1'b1;
        err_set    = dest_bad || (state_q == ST_IN_PKT);
        state_d    = in_tail ? ST_IDLE : ST_IN_PKT;
      end else if (state_q == ST_IDLE) begin
        // Orphan body/tail: eject it and stay idle.
        dir_sel = DIR_LOCAL;
        err_set = 1'b1;
      end else begin
        dir_sel = route_q;
        if (in_tail) begin
          state_d = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_flit  <= '0;
      dir_q     <= DIR_LOCAL;
      route_q   <= DIR_LOCAL;
      err       <= 1'b0;
    end else begin
      if (in_fire) begin
        out_valid <= 1'b1;
        out_flit  <= in_flit;
        dir_q     <= dir_sel;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (route_load) begin
        route_q <= head_dir;
      end
      if (err_set) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ring_route_compute.sv
// Bench for ring_route_compute: five instances (shortest, transit east, random,
// clockwise, transit west) share stimulus and are checked against a packet-level model.
module tb_ring_route_compute;
  import ring_pkg::*;

  localparam int N   = 8;
  localparam int RID = 2;
  localparam int IDW = 16;
  localparam int PS  = 49;
  localparam int ND  = 5;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [PS-1:0] in_flit;
  logic          in_valid, in_head, in_tail, out_ready;
  logic [PS-1:0] of_s [ND];
  logic          ov_s [ND];
  logic [1:0]    od_s [ND];
  logic          er_s [ND];
  logic          ir_s [ND];

  ring_route_compute #(.NUM_NODES(N), .ROUTER_ID(RID), .ID_W(IDW), .PACKET_SIZE(PS),
    .IN_PORT(0), .ROUTING(1), .LFSR_SEED(SEED)) dut_sp (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_head(in_head),
    .in_tail(in_tail), .in_ready(ir_s[0]), .out_flit(of_s[0]), .out_valid(ov_s[0]),
    .out_ready(out_ready), .out_dir(od_s[0]), .err(er_s[0]));

  ring_route_compute #(.NUM_NODES(N), .ROUTER_ID(RID), .ID_W(IDW), .PACKET_SIZE(PS),
    .IN_PORT(1), .ROUTING(0), .LFSR_SEED(SEED)) dut_te (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_head(in_head),
    .in_tail(in_tail), .in_ready(ir_s[1]), .out_flit(of_s[1]), .out_valid(ov_s[1]),
    .out_ready(out_ready), .out_dir(od_s[1]), .err(er_s[1]));

  ring_route_compute #(.NUM_NODES(N), .ROUTER_ID(RID), .ID_W(IDW), .PACKET_SIZE(PS),
    .IN_PORT(0), .ROUTING(0), .LFSR_SEED(SEED)) dut_rnd (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_head(in_head),
    .in_tail(in_tail), .in_ready(ir_s[2]), .out_flit(of_s[2]), .out_valid(ov_s[2]),
    .out_ready(out_ready), .out_dir(od_s[2]), .err(er_s[2]));

  ring_route_compute #(.NUM_NODES(N), .ROUTER_ID(RID), .ID_W(IDW), .PACKET_SIZE(PS),
    .IN_PORT(0), .ROUTING(2), .LFSR_SEED(SEED)) dut_cw (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_head(in_head),
    .in_tail(in_tail), .in_ready(ir_s[3]), .out_flit(of_s[3]), .out_valid(ov_s[3]),
    .out_ready(out_ready), .out_dir(od_s[3]), .err(er_s[3]));

  ring_route_compute #(.NUM_NODES(N), .ROUTER_ID(RID), .ID_W(IDW), .PACKET_SIZE(PS),
    .IN_PORT(2), .ROUTING(1), .LFSR_SEED(SEED)) dut_tw (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_head(in_head),
    .in_tail(in_tail), .in_ready(ir_s[4]), .out_flit(of_s[4]), .out_valid(ov_s[4]),
    .out_ready(out_ready), .out_dir(od_s[4]), .err(er_s[4]));

  int cfg_port [ND] = '{0, 1, 0, 0, 2};
  int cfg_mode [ND] = '{1, 0, 0, 2, 1};

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Packet-level reference state
  bit            m_valid, m_err, m_in_pkt;
  logic [PS-1:0] m_flit;
  logic [1:0]    m_dir   [ND];
  logic [1:0]    m_route [ND];
  logic [15:0]   m_lfsr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] lfsr_ref_step(input logic [15:0] s);
    int v, fb;
    v  = int'(s);
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return 16'(((v << 1) | fb) & 32'hFFFF);
  endfunction

  function automatic logic [1:0] ref_route(input int port, input int mode, input int dest,
                                           input logic [15:0] lf);
    if (dest >= N || dest == RID) return 2'b00;
    if (port == 1) return 2'b10;
    if (port == 2) return 2'b01;
    if (mode == 0) return lf[0] ? 2'b10 : 2'b01;
    if (mode == 1) return (((dest - RID + N) % N) <= N / 2) ? 2'b01 : 2'b10;
    return 2'b01;
  endfunction

  function automatic logic [PS-1:0] mk_flit(input int dest);
    logic [63:0]   r;
    logic [PS-1:0] f;
    r = {$urandom(), $urandom()};
    f = r[PS-1:0];
    f[IDW-1:0] = IDW'(dest);
    return f;
  endfunction

  task automatic check_all();
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("out_valid[%0d]", k), 64'(ov_s[k]), 64'(m_valid));
      chk($sformatf("err[%0d]", k), 64'(er_s[k]), 64'(m_err));
      if (m_valid) begin
        chk($sformatf("out_flit[%0d]", k), 64'(of_s[k]), 64'(m_flit));
        chk($sformatf("out_dir[%0d]", k), 64'(od_s[k]), 64'(m_dir[k]));
      end
    end
  endtask

  // Called just after a rising edge; returns just after the next rising edge.
  task automatic cycle(input bit v, input bit h, input bit t, input logic [PS-1:0] f,
                       input bit ordy);
    bit         fire;
    int         dest;
    logic [1:0] nd [ND];
    in_valid = v; in_head = h; in_tail = t; in_flit = f; out_ready = ordy;
    @(negedge clk);
    fire = v && (!m_valid || ordy);
    for (int k = 0; k < ND; k++)
      chk($sformatf("in_ready[%0d]", k), 64'(ir_s[k]), 64'(!m_valid || ordy));
    @(posedge clk);
    dest = int'(f[IDW-1:0]);
    if (fire) begin
      for (int k = 0; k < ND; k++) begin
        if (h) nd[k] = ref_route(cfg_port[k], cfg_mode[k], dest, m_lfsr);
        else if (!m_in_pkt) nd[k] = 2'b00;
        else nd[k] = m_route[k];
        if (h) m_route[k] = nd[k];
        m_dir[k] = nd[k];
      end
      if (h && (dest >= N || m_in_pkt)) m_err = 1'b1;
      if (!h && !m_in_pkt) m_err = 1'b1;
      if (h) m_in_pkt = !t;
      else if (t) m_in_pkt = 1'b0;
      if (h) m_lfsr = lfsr_ref_step(m_lfsr);
      m_valid = 1'b1;
      m_flit  = f;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    m_valid = 0; m_err = 0; m_in_pkt = 0; m_flit = '0; m_lfsr = SEED;
    for (int k = 0; k < ND; k++) begin
      m_dir[k] = 2'b00; m_route[k] = 2'b00;
      chk($sformatf("rst out_valid[%0d]", k), 64'(ov_s[k]), 64'd0);
      chk($sformatf("rst out_dir[%0d]", k), 64'(od_s[k]), 64'd0);
      chk($sformatf("rst out_flit[%0d]", k), 64'(of_s[k]), 64'd0);
      chk($sformatf("rst err[%0d]", k), 64'(er_s[k]), 64'd0);
    end
    rst = 1'b0;
  endtask

  typedef struct {
    int         dest;
    logic [1:0] sp, te, cw, tw;
  } vec_t;

  initial begin
    vec_t          tbl [8];
    logic [PS-1:0] f, held;

    tbl[0] = '{5, 2'b01, 2'b10, 2'b01, 2'b01};
    tbl[1] = '{6, 2'b01, 2'b10, 2'b01, 2'b01};
    tbl[2] = '{7, 2'b10, 2'b10, 2'b01, 2'b01};
    tbl[3] = '{2, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[4] = '{0, 2'b10, 2'b10, 2'b01, 2'b01};
    tbl[5] = '{1, 2'b10, 2'b10, 2'b01, 2'b01};
    tbl[6] = '{3, 2'b01, 2'b10, 2'b01, 2'b01};
    tbl[7] = '{4, 2'b01, 2'b10, 2'b01, 2'b01};

    rst = 1'b1; in_valid = 0; in_head = 0; in_tail = 0; in_flit = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    cycle(0, 0, 0, '0, 0);

    // Single-flit heads, each checked one cycle after acceptance.
    for (int i = 0; i < 8; i++) begin
      cycle(1, 1, 1, mk_flit(tbl[i].dest), 1);
      chk($sformatf("tbl%0d sp", i), 64'(od_s[0]), 64'(tbl[i].sp));
      chk($sformatf("tbl%0d te", i), 64'(od_s[1]), 64'(tbl[i].te));
      chk($sformatf("tbl%0d cw", i), 64'(od_s[3]), 64'(tbl[i].cw));
      chk($sformatf("tbl%0d tw", i), 64'(od_s[4]), 64'(tbl[i].tw));
    end

    // 4-flit packet to node 4 with a 3-cycle stall while flit 2 is at the output.
    cycle(1, 1, 0, mk_flit(4), 1);
    f = mk_flit(4);
    cycle(1, 0, 0, f, 1);
    held = mk_flit(4);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, held, 0);
      chk("stall flit held", 64'(of_s[1]), 64'(f));
      chk("stall in_ready", 64'(ir_s[1]), 64'd0);
    end
    cycle(1, 0, 0, held, 1);
    cycle(1, 0, 1, mk_flit(4), 1);
    chk("transit tail dir", 64'(od_s[1]), 64'(2'b10));
    cycle(0, 0, 0, '0, 1);

    // Random-mode heads with body flits in between.
    for (int i = 0; i < 8; i++) begin
      cycle(1, 1, 0, mk_flit(3 + (i % 5)), 1);
      cycle(1, 0, 0, mk_flit(0), 1);
      cycle(1, 0, 1, mk_flit(0), 1);
    end

    // Missing tail: second head routed by its own destination.
    do_reset();
    cycle(1, 1, 0, mk_flit(5), 1);
    chk("first head no err", 64'(er_s[0]), 64'd0);
    cycle(1, 1, 0, mk_flit(7), 1);
    chk("missing tail err", 64'(er_s[0]), 64'd1);
    chk("second head dir", 64'(od_s[0]), 64'(2'b10));
    cycle(1, 0, 1, mk_flit(0), 1);
    chk("second pkt tail dir", 64'(od_s[0]), 64'(2'b10));

    // Reset mid-packet, then an orphan body flit.
    do_reset();
    cycle(1, 1, 0, mk_flit(3), 1);
    do_reset();
    chk("mid-pkt rst valid", 64'(ov_s[0]), 64'd0);
    cycle(1, 0, 0, mk_flit(3), 1);
    chk("orphan dir", 64'(od_s[0]), 64'(2'b00));
    chk("orphan err", 64'(er_s[0]), 64'd1);

    // Out-of-range destination: eject and sticky err.
    do_reset();
    cycle(1, 1, 1, mk_flit(9), 1);
    chk("dest9 dir", 64'(od_s[0]), 64'(2'b00));
    chk("dest9 err", 64'(er_s[0]), 64'd1);
    for (int i = 0; i < 4; i++) cycle(1, 1, 1, mk_flit(i), 1);
    chk("err sticky", 64'(er_s[2]), 64'd1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      cycle(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 2) == 0),
            bit'($urandom_range(0, 2) == 0), mk_flit($urandom_range(0, 9)),
            bit'($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
